// File: rtl/rtc_read_sequencer.sv
// RTC register read sequencer: phase count, register stepping and data capture.
// Define RTC_READ_CONTINUOUS_EN to restart sweeps back-to-back while EnR stays high.
module rtc_read_sequencer #(
    parameter int          CYCLE_LAST  = 84,
    parameter int          CAPTURE_CNT = 68,
    parameter int          NUM_REGS    = 6,
    parameter logic [7:0]  ADDR_BASE   = 8'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EnR,
    input  logic [7:0] data_in,
    output logic [6:0] count,
    output logic [7:0] addr,
    output logic [2:0] reg_idx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [6:0] COUNT_IDLE = 7'd127;
    localparam logic [6:0] COUNT_LAST = 7'(CYCLE_LAST);
    localparam logic [6:0] COUNT_CAP  = 7'(CAPTURE_CNT);
    localparam logic [2:0] IDX_LAST   = 3'(NUM_REGS - 1);

    state_t     state, state_n;
    logic       enr_q;
    logic       start_q;
    logic [6:0] count_n;
    logic [2:0] reg_idx_n;
    logic [7:0] addr_n;
    logic [7:0] data_out_n;
    logic       data_valid_n;
    logic       busy_n;
    logic       done_n;

    // The start pulse is registered, so a sweep begins one cycle after the edge is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            enr_q      <= 1'b0;
            start_q    <= 1'b0;
            count      <= COUNT_IDLE;
            reg_idx    <= 3'd0;
            addr       <= ADDR_BASE;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            enr_q      <= EnR;
            start_q    <= EnR & ~enr_q;
            count      <= count_n;
            reg_idx    <= reg_idx_n;
            addr       <= addr_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        count_n      = count;
        reg_idx_n    = reg_idx;
        addr_n       = addr;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        busy_n       = busy;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                count_n = COUNT_IDLE;
                busy_n  = 1'b0;
                if (start_q) begin
                    state_n   = RUN;
                    count_n   = 7'd0;
                    reg_idx_n = 3'd0;
                    addr_n    = ADDR_BASE;
                    busy_n    = 1'b1;
                end
            end
            RUN: begin
                count_n = count + 7'd1;
                busy_n  = 1'b1;
                if (count == COUNT_CAP) begin
                    data_out_n   = data_in;
                    data_valid_n = 1'b1;
                end
                if (count == COUNT_LAST) begin
                    if (reg_idx < IDX_LAST) begin
                        count_n   = 7'd0;
                        reg_idx_n = reg_idx + 3'd1;
                        addr_n    = addr + 8'd1;
                    end else begin
                        done_n    = 1'b1;
                        reg_idx_n = 3'd0;
                        addr_n    = ADDR_BASE;
`ifdef RTC_READ_CONTINUOUS_EN
                        // A held request chains the next sweep with no idle gap.
                        if (EnR) begin
                            count_n = 7'd0;
                        end else begin
                            state_n = IDLE;
                            count_n = COUNT_IDLE;
                            busy_n  = 1'b0;
                        end
`else
                        state_n = IDLE;
                        count_n = COUNT_IDLE;
                        busy_n  = 1'b0;
`endif
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = COUNT_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed self-checking bench for rtc_read_sequencer in its default build.
module tb_rtc_read_sequencer;

    logic       clk;
    logic       reset;
    logic       EnR;
    logic [7:0] data_in;
    logic [6:0] count;
    logic [7:0] addr;
    logic [2:0] reg_idx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       done;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_dout;

    rtc_read_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .EnR        (EnR),
        .data_in    (data_in),
        .count      (count),
        .addr       (addr),
        .reg_idx    (reg_idx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_count"}, {1'b0, count}, 8'd127);
        check_output({tag, "_reg_idx"}, {5'd0, reg_idx}, 8'd0);
        check_output({tag, "_addr"}, addr, 8'h21);
        check_output({tag, "_data_out"}, data_out, 8'h00);
        check_output({tag, "_valid"}, {7'd0, data_valid}, 8'd0);
        check_output({tag, "_busy"}, {7'd0, busy}, 8'd0);
        check_output({tag, "_done"}, {7'd0, done}, 8'd0);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check_output({tag, "_count"}, {1'b0, count}, 8'd127);
            check_output({tag, "_busy"}, {7'd0, busy}, 8'd0);
            check_output({tag, "_done"}, {7'd0, done}, 8'd0);
            check_output({tag, "_valid"}, {7'd0, data_valid}, 8'd0);
        end
    endtask

    // One full sweep; per_reg selects 8'h10..8'h60 (else 8'h59), abort_at >= 0 resets mid-sweep.
    task automatic apply_sweep(input bit per_reg, input bit extra_edge, input int abort_at);
        int         r;
        int         c;
        logic [7:0] val;
        @(negedge clk);
        EnR     = 1'b1;
        data_in = per_reg ? 8'hEE : 8'h59;
        @(negedge clk);
        check_output("latency_count", {1'b0, count}, 8'd127);
        check_output("latency_busy", {7'd0, busy}, 8'd0);
        EnR = 1'b0;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            r   = i / 85;
            c   = i % 85;
            val = per_reg ? 8'((r + 1) * 16) : 8'h59;
            if (c == 69) exp_dout = val;
            check_output("run_count", {1'b0, count}, 8'(c));
            check_output("run_reg_idx", {5'd0, reg_idx}, 8'(r));
            check_output("run_addr", addr, 8'(8'h21 + r));
            check_output("run_busy", {7'd0, busy}, 8'd1);
            check_output("run_done", {7'd0, done}, 8'd0);
            check_output("run_valid", {7'd0, data_valid}, (c == 69) ? 8'd1 : 8'd0);
            check_output("run_data_out", data_out, exp_dout);
            if (per_reg) data_in = (c == 68) ? val : 8'hEE;
            if (extra_edge && i == 265) EnR = 1'b1;
            if (extra_edge && i == 268) EnR = 1'b0;
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check_reset_values("abort");
                exp_dout = 8'h00;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_output("end_count", {1'b0, count}, 8'd127);
        check_output("end_done", {7'd0, done}, 8'd1);
        check_output("end_busy", {7'd0, busy}, 8'd0);
        check_output("end_reg_idx", {5'd0, reg_idx}, 8'd0);
        check_output("end_addr", addr, 8'h21);
        check_output("end_valid", {7'd0, data_valid}, 8'd0);
        check_output("end_data_out", data_out, exp_dout);
        @(negedge clk);
        check_output("post_done", {7'd0, done}, 8'd0);
        check_output("post_count", {1'b0, count}, 8'd127);
    endtask

    initial begin
        reset    = 1'b1;
        EnR      = 1'b0;
        data_in  = 8'h00;
        exp_dout = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        check_idle("idle", 20);
        apply_sweep(1'b0, 1'b0, -1);
        apply_sweep(1'b1, 1'b0, -1);
        apply_sweep(1'b1, 1'b1, -1);
        apply_sweep(1'b0, 1'b0, 210);
        check_idle("after_abort", 10);
        apply_sweep(1'b1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
